// File: rtl/data_island_packet_serializer_if.sv
// Packet-selection <-> serializer bus: island timing, selected packet, pacing and serialized output.
interface data_island_packet_serializer_if;
  logic         data_island_period;
  logic         data_island_next;
  logic [23:0]  header;
  logic [223:0] sub;
  logic         packet_enable;
  logic [4:0]   packet_pixel_counter;
  logic [8:0]   packet_data;
  logic         packet_data_valid;

  // Selection stage / island timing side
  modport master (
    output data_island_period, data_island_next, header, sub,
    input  packet_enable, packet_pixel_counter, packet_data, packet_data_valid
  );

  // Serializer side
  modport slave (
    input  data_island_period, data_island_next, header, sub,
    output packet_enable, packet_pixel_counter, packet_data, packet_data_valid
  );
endinterface

// File: rtl/data_island_packet_serializer.sv
// HDMI data-island packet serializer: captures header + 4 subpackets at pixel 0,
// appends bit-serial BCH parity and emits 9 bits per pixel over 32 pixels.

// One subpacket lane: 56 data bits as 28 even/odd pairs, then 8 parity bits as 4 pairs.
module data_island_subpacket_lane #(
  parameter logic [7:0] ECC_POLY = 8'h83
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        active_i,
  input  logic [4:0]  k_i,
  input  logic [55:0] sub_i,
  output logic        e_o,
  output logic        o_o
);
  logic [55:0] shd_q, shd_d, cur;
  logic [7:0]  par_q, par_d, p_base, p_mid;
  logic [5:0]  idx;

  function automatic logic [7:0] bch_step(input logic [7:0] p, input logic d);
    return (p >> 1) ^ ((p[0] ^ d) ? ECC_POLY : 8'h00);
  endfunction

  // Pick live port at pixel 0, shadow afterwards; two parity updates per data pixel
  always_comb begin
    cur    = (k_i == 5'd0) ? sub_i : shd_q;
    shd_d  = (active_i && k_i == 5'd0) ? sub_i : shd_q;
    p_base = (k_i == 5'd0) ? 8'h00 : par_q;
    idx    = {k_i, 1'b0};
    par_d  = par_q;
    p_mid  = 8'h00;
    if (k_i < 5'd28) begin
      e_o   = cur[idx];
      o_o   = cur[idx + 6'd1];
      p_mid = bch_step(p_base, e_o);
      if (active_i) par_d = bch_step(p_mid, o_o);
    end else begin
      // 2k-56 has the same low three bits as 2k
      e_o = par_q[{k_i[1:0], 1'b0}];
      o_o = par_q[{k_i[1:0], 1'b1}];
    end
  end

  // Shadow and parity state
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shd_q <= '0;
      par_q <= '0;
    end else begin
      shd_q <= shd_d;
      par_q <= par_d;
    end
  end
endmodule

module data_island_packet_serializer #(
  parameter logic [7:0] ECC_POLY = 8'h83
) (
  input  logic                          clk_pixel,
  input  logic                          reset,
  data_island_packet_serializer_if.slave dif
);
  localparam int NUM_LANES = 4;

  logic [4:0]           cnt_q, cnt_d;
  logic [23:0]          hdr_q, hdr_d, hdr_cur;
  logic [7:0]           hp_q, hp_d;
  logic [8:0]           pd_q, pd_d;
  logic                 vld_q;
  logic                 h;
  logic [NUM_LANES-1:0] e, o;

  function automatic logic [7:0] bch_step(input logic [7:0] p, input logic d);
    return (p >> 1) ^ ((p[0] ^ d) ? ECC_POLY : 8'h00);
  endfunction

  // Upstream selects the next packet one cycle before each packet start
  assign dif.packet_enable = dif.data_island_next &
                             (~dif.data_island_period | (cnt_q == 5'd31));
  assign dif.packet_pixel_counter = cnt_q;
  assign dif.packet_data          = pd_q;
  assign dif.packet_data_valid    = vld_q;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      data_island_subpacket_lane #(.ECC_POLY(ECC_POLY)) u_lane (
        .clk_i    (clk_pixel),
        .rst_i    (reset),
        .active_i (dif.data_island_period),
        .k_i      (cnt_q),
        .sub_i    (dif.sub[56*gi +: 56]),
        .e_o      (e[gi]),
        .o_o      (o[gi])
      );
    end
  endgenerate

  // Pixel counter: runs only inside an island, wraps every 32 pixels
  always_comb begin
    cnt_d = dif.data_island_period ? cnt_q + 5'd1 : 5'd0;
  end

  // Header lane: 24 data bits then 8 parity bits, one per pixel
  always_comb begin
    hdr_cur = (cnt_q == 5'd0) ? dif.header : hdr_q;
    hdr_d   = (dif.data_island_period && cnt_q == 5'd0) ? dif.header : hdr_q;
    hp_d    = hp_q;
    if (cnt_q < 5'd24) begin
      h = hdr_cur[cnt_q];
      if (dif.data_island_period)
        hp_d = bch_step((cnt_q == 5'd0) ? 8'h00 : hp_q, h);
    end else begin
      // k-24 has the same low three bits as k
      h = hp_q[cnt_q[2:0]];
    end
  end

  // Output word, forced to zero outside an island
  always_comb begin
    pd_d = dif.data_island_period ? {o, e, h} : 9'd0;
  end

  // Counter, header state and registered outputs
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      cnt_q <= '0;
      hdr_q <= '0;
      hp_q  <= '0;
      pd_q  <= '0;
      vld_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      hdr_q <= hdr_d;
      hp_q  <= hp_d;
      pd_q  <= pd_d;
      vld_q <= dif.data_island_period;
    end
  end
endmodule

// File: tb/tb_data_island_packet_serializer.sv
// Scoreboard bench for the data-island packet serializer.
module tb_data_island_packet_serializer;
  logic clk_pixel = 1'b0;
  logic reset;

  data_island_packet_serializer_if dif ();

  data_island_packet_serializer #(.ECC_POLY(8'h83)) dut (
    .clk_pixel (clk_pixel),
    .reset     (reset),
    .dif       (dif)
  );

  always #5 clk_pixel = ~clk_pixel;

  typedef struct {
    int         k;
    logic [8:0] d;
  } sb_t;

  sb_t          sb[$];
  int           n_tests = 0;
  int           n_fail  = 0;
  int           n_en    = 0;
  int           mck     = 0;
  logic [23:0]  cap_h;
  logic [223:0] cap_s;
  logic [8:0]   obs[32];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] bch(input logic [7:0] p, input logic d);
    return (p >> 1) ^ ((p[0] ^ d) ? 8'h83 : 8'h00);
  endfunction

  // Reference: build full codewords {parity, data} and pick bit k / pair k
  function automatic logic [8:0] exp_pix(input logic [23:0] h, input logic [223:0] s, input int k);
    logic [31:0] hcw;
    logic [63:0] cw;
    logic [7:0]  p;
    logic [8:0]  r;
    p = 8'h00;
    for (int i = 0; i < 24; i++) p = bch(p, h[i]);
    hcw  = {p, h};
    r[0] = hcw[k];
    for (int j = 0; j < 4; j++) begin
      cw[55:0] = s[56*j +: 56];
      p = 8'h00;
      for (int b = 0; b < 56; b++) p = bch(p, cw[b]);
      cw[63:56] = p;
      r[1+j] = cw[2*k];
      r[5+j] = cw[2*k+1];
    end
    return r;
  endfunction

  function automatic logic [223:0] rnd224();
    return {$urandom(), $urandom(), $urandom(), $urandom(),
            $urandom(), $urandom(), $urandom()};
  endfunction

  // One pixel: drive, check pacing, push expected, clock, check output
  task automatic step(input bit r, input bit per, input bit nxt,
                      input logic [23:0] h, input logic [223:0] s);
    sb_t e;
    bit  ev;
    reset = r;
    dif.data_island_period = per;
    dif.data_island_next   = nxt;
    dif.header = h;
    dif.sub    = s;
    #1;
    chk("cnt", 32'(dif.packet_pixel_counter), 32'(mck));
    chk("en", 32'(dif.packet_enable), 32'(nxt & (!per | (mck == 31))));
    if (dif.packet_enable) n_en++;
    if (!r && per) begin
      if (mck == 0) begin
        cap_h = h;
        cap_s = s;
      end
      e.k = mck;
      e.d = exp_pix(cap_h, cap_s, mck);
      sb.push_back(e);
    end
    @(posedge clk_pixel);
    ev  = !r && per;
    mck = ev ? (mck + 1) % 32 : 0;
    #1;
    chk("vld", 32'(dif.packet_data_valid), 32'(ev));
    if (dif.packet_data_valid === 1'b1) begin
      if (sb.size() == 0) chk("sb_under", 32'd1, 32'd0);
      else begin
        e = sb.pop_front();
        chk($sformatf("data_k%0d", e.k), 32'(dif.packet_data), 32'(e.d));
        obs[e.k] = dif.packet_data;
      end
    end else begin
      chk("data_idle", 32'(dif.packet_data), 32'd0);
    end
  endtask

  // Island of n pixels; optional reset at pixel rst_at; vary changes packet per enable and at k=10
  task automatic island(input int n, input int rst_at, input logic [23:0] h0,
                        input logic [223:0] s0, input bit vary);
    logic [23:0]  h;
    logic [223:0] s;
    h = h0;
    s = s0;
    step(0, 0, 1, h, s);
    for (int j = 0; j < n; j++) begin
      if (vary && j % 32 == 0 && j > 0) begin
        h = $urandom();
        s = rnd224();
      end
      if (vary && j % 32 == 10) begin
        h = ~h;
        s = ~s;
      end
      if (j == rst_at) begin
        step(1, 1, 1, h, s);
        break;
      end
      step(0, 1, j < n - 1, h, s);
    end
    repeat (3) step(0, 0, 0, h, s);
  endtask

  initial begin
    logic [223:0] s3;
    reset = 1'b1;
    dif.data_island_period = 1'b0;
    dif.data_island_next   = 1'b0;
    dif.header = '0;
    dif.sub    = '0;
    @(posedge clk_pixel);
    #1;
    chk("rst_cnt",  32'(dif.packet_pixel_counter), 32'd0);
    chk("rst_vld",  32'(dif.packet_data_valid), 32'd0);
    chk("rst_data", 32'(dif.packet_data), 32'd0);

    // All-zero packet
    n_en = 0;
    island(32, -1, 24'h0, '0, 0);
    chk("t1_en", 32'(n_en), 32'd1);

    // Single header bit 23
    island(32, -1, 24'h800000, '0, 0);
    chk("t2_h23", 32'(obs[23]), 32'h001);
    chk("t2_hp", 32'({obs[31][0], obs[30][0], obs[29][0], obs[28][0],
                      obs[27][0], obs[26][0], obs[25][0], obs[24][0]}), 32'h83);

    // Single subpacket-0 bit 55
    s3 = '0;
    s3[55] = 1'b1;
    island(32, -1, 24'h0, s3, 0);
    chk("t3_k27", 32'(obs[27]), 32'h020);
    chk("t3_k28", 32'(obs[28]), 32'h022);
    chk("t3_k29", 32'(obs[29]), 32'h000);
    chk("t3_k30", 32'(obs[30]), 32'h000);
    chk("t3_k31", 32'(obs[31]), 32'h020);

    // Two back-to-back packets with upstream changes
    n_en = 0;
    island(64, -1, 24'h3c5a96, rnd224(), 1);
    chk("t4_en", 32'(n_en), 32'd2);

    // Reset mid-packet, then a clean island
    island(32, 15, 24'habcdef, rnd224(), 0);
    island(32, -1, 24'h123456, rnd224(), 0);

    // Island truncated at k=20, then a clean island
    n_en = 0;
    island(21, -1, 24'h0f0f0f, rnd224(), 0);
    chk("t6_en", 32'(n_en), 32'd1);
    island(32, -1, 24'h987654, rnd224(), 0);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
